// File: rtl/async_hyper_harness_pkg.sv
// Shared definitions for the asynchronous HyperLTL harness: phase encoding
// and the counter-width helper used by the top and the per-side guards.
package async_hyper_harness_pkg;

  typedef enum logic [1:0] {
    PH_LOAD = 2'd0,
    PH_RUN  = 2'd1,
    PH_DONE = 2'd2
  } phase_t;

  // Bits needed to hold values 0..n inclusive (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/async_hyper_harness_stutter_guard.sv
// Per-side bookkeeping: step counter, consecutive-stutter counter and the
// finished flag. The stutter decision itself is made in the top; this block
// only records its consequences.
module async_hyper_harness_stutter_guard
  import async_hyper_harness_pkg::*;
#(
  parameter int RUN_STEPS   = 16,
  parameter int MAX_STUTTER = 3,
  localparam int CW = cnt_w(RUN_STEPS),
  localparam int SW = cnt_w(MAX_STUTTER)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          stut,
  output logic [CW-1:0] steps,
  output logic [SW-1:0] stut_cnt,
  output logic          fin
);

  // Saturating increment so a long forced stutter cannot wrap the counter.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(MAX_STUTTER)) ? v : v + SW'(1);
  endfunction

  assign fin = (steps == CW'(RUN_STEPS));

  // Step counter: advances on every enabled step, parks at RUN_STEPS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      steps <= '0;
    else if (en && !fin)
      steps <= steps + CW'(1);
  end

  // Consecutive-stutter counter: cleared by a step, bumped by a counted stutter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stut_cnt <= '0;
    else if (en)
      stut_cnt <= '0;
    else if (stut)
      stut_cnt <= sat_inc(stut_cnt);
  end

endmodule

// File: rtl/async_hyper_harness.sv
// Top of the harness: shifts in the secret during LOAD, then paces the source
// and target codeblocks with step enables, bounding stutter runs and the lag
// between them, and latches any public-output divergence seen at aligned steps.
module async_hyper_harness
  import async_hyper_harness_pkg::*;
#(
  parameter int SECRET_W    = 1,
  parameter int LOAD_CYCLES = 1,
  parameter int PUB_W       = 1,
  parameter int MAX_STUTTER = 3,
  parameter int MAX_LAG     = 2,
  parameter int RUN_STEPS   = 16,
  localparam int SV_W = SECRET_W * LOAD_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SECRET_W-1:0] secret_in,
  input  logic                stut_req_src,
  input  logic                stut_req_tar,
  input  logic [PUB_W-1:0]    pub_src,
  input  logic [PUB_W-1:0]    pub_tar,
  output logic [SV_W-1:0]     secret_v,
  output logic                en_src,
  output logic                en_tar,
  output logic                st_src,
  output logic                st_tar,
  output logic [1:0]          phase,
  output logic                mismatch
);

  localparam int CW = cnt_w(RUN_STEPS);
  localparam int SW = cnt_w(MAX_STUTTER);
  localparam int LW = cnt_w(LOAD_CYCLES);

  phase_t          phase_q, phase_d;
  logic [LW-1:0]   load_cnt;
  logic            load_last;
  logic [CW-1:0]   steps_src, steps_tar;
  logic [SW-1:0]   stut_cnt_src, stut_cnt_tar;
  logic            fin_src, fin_tar;
  logic            stut_src, stut_tar;
  logic signed [CW:0] lag;
  logic            both_p1;

  assign phase     = phase_q;
  assign load_last = (load_cnt == LW'(LOAD_CYCLES - 1));
  assign lag       = $signed({1'b0, steps_src}) - $signed({1'b0, steps_tar});

  // A stutter is counted only in RUN and only for a side that is not finished.
  assign stut_src = (phase_q == PH_RUN) && st_src && !fin_src;
  assign stut_tar = (phase_q == PH_RUN) && st_tar && !fin_tar;

  async_hyper_harness_stutter_guard #(
    .RUN_STEPS  (RUN_STEPS),
    .MAX_STUTTER(MAX_STUTTER)
  ) u_guard_src (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en_src),
    .stut    (stut_src),
    .steps   (steps_src),
    .stut_cnt(stut_cnt_src),
    .fin     (fin_src)
  );

  async_hyper_harness_stutter_guard #(
    .RUN_STEPS  (RUN_STEPS),
    .MAX_STUTTER(MAX_STUTTER)
  ) u_guard_tar (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en_tar),
    .stut    (stut_tar),
    .steps   (steps_tar),
    .stut_cnt(stut_cnt_tar),
    .fin     (fin_tar)
  );

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase_q <= PH_LOAD;
    else
      phase_q <= phase_d;
  end

  // Phase transitions: LOAD for LOAD_CYCLES cycles, RUN until both sides finish.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_LOAD: if (load_last) phase_d = PH_RUN;
      PH_RUN:  if (fin_src && fin_tar) phase_d = PH_DONE;
      default: phase_d = PH_DONE;
    endcase
  end

  // Stutter/enable decision: finished > lag bound > request with run limit,
  // and the target is forced to step if both would otherwise stall.
  always_comb begin
    st_src = 1'b1;
    st_tar = 1'b1;
    if (phase_q == PH_RUN) begin
      if (fin_src)
        st_src = 1'b1;
      else if (int'(lag) >= MAX_LAG)
        st_src = 1'b1;
      else if (int'(lag) <= -MAX_LAG)
        st_src = 1'b0;
      else
        st_src = stut_req_src && (int'(stut_cnt_src) < MAX_STUTTER);

      if (fin_tar)
        st_tar = 1'b1;
      else if (int'(lag) <= -MAX_LAG)
        st_tar = 1'b1;
      else if (int'(lag) >= MAX_LAG)
        st_tar = 1'b0;
      else
        st_tar = stut_req_tar && (int'(stut_cnt_tar) < MAX_STUTTER);

      if (st_src && st_tar && !fin_src && !fin_tar)
        st_tar = 1'b0;
    end
    en_src = (phase_q == PH_RUN) && !st_src;
    en_tar = (phase_q == PH_RUN) && !st_tar;
  end

  // Secret shifter and load-cycle counter, active only during LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      secret_v <= '0;
      load_cnt <= '0;
    end else if (phase_q == PH_LOAD) begin
      secret_v <= (secret_v << SECRET_W) | SV_W'(secret_in);
      load_cnt <= load_cnt + LW'(1);
    end
  end

  // Alignment stage: compare public outputs the cycle after a joint step,
  // once the codeblocks' outputs reflect that step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      both_p1  <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      both_p1 <= en_src && en_tar;
      if ((phase_q == PH_RUN || phase_q == PH_DONE) && both_p1 && (pub_src != pub_tar))
        mismatch <= 1'b1;
    end
  end

endmodule
